// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;

   // Canonical bubble instruction: addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   // Decode field positions inside a 32-bit instruction
   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned OPCODE_MSB = 6;
   localparam int unsigned F3_LSB     = 12;
   localparam int unsigned F3_MSB     = 14;
   localparam int unsigned F7_B6_POS  = 30;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; push and pop may coincide at any occupancy.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_count = wr_ptr - rd_ptr;
   assign o_data  = mem[rd_ptr[AW-1:0]];

   // A pop on a full FIFO frees the slot the simultaneous push writes into
   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~o_full | do_pop);

   // Pointer update; clear wins over push/pop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (i_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write
   always_ff @(posedge i_clk) begin
      if (do_push && !i_clear) mem[wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: PC generator, in-order multi-outstanding imem port,
// prefetch queue and IF/ID register with redirect cancellation.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clk_en,
   input  logic                    i_pc_wr_en_h,
   input  logic                    i_redirect_h,
   input  logic [XLEN-1:0]         i_redirect_pc,
   input  logic                    i_if_id_stall_h,
   input  logic                    i_if_id_flush_h,
   output logic                    o_imem_req,
   output logic [XLEN-1:0]         o_imem_addr,
   input  logic                    i_imem_gnt,
   input  logic                    i_imem_rvalid,
   input  logic [31:0]             i_imem_rdata,
   output logic                    o_valid_d,
   output logic [31:0]             o_instr_d,
   output logic [XLEN-1:0]         o_pc_d,
   output logic [XLEN-1:0]         o_pc_plus4_d,
   output logic [6:0]              o_opcode_d,
   output logic [2:0]              o_f3_d,
   output logic                    o_f7_b6_d,
   output logic [$clog2(DEPTH):0]  o_q_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = XLEN + INSTR_W;
   localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0] resp_pc, resp_pc_nxt;
   logic [CW-1:0]   outstanding, outstanding_nxt;
   logic [CW-1:0]   discard, discard_nxt;

   logic            valid_nxt;
   logic [31:0]     instr_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] pc_plus4_nxt;

   logic [CW-1:0]   q_count;
   logic            q_empty;
   logic            q_full;
   logic [EW-1:0]   q_head;
   logic            q_push;
   logic            q_pop;
   logic            q_clear;

   logic [CW:0]     q_plus_out;
   logic [CW:0]     owed;
   logic [CW:0]     owed_after;
   logic            req;
   logic            issue;
   logic            resp_drop;
   logic            resp_take;

   // Issue cap: neither the queue nor the discard counter can overflow
   assign q_plus_out = (CW+1)'(q_count) + (CW+1)'(outstanding);
   assign owed       = (CW+1)'(outstanding) + (CW+1)'(discard);
   assign req = i_clk_en & ~i_rst & i_pc_wr_en_h & ~i_redirect_h
              & (q_plus_out < DEPTH_LIM) & (owed < DEPTH_LIM);
   assign issue = req & i_imem_gnt;

   // Responses owed to cancelled requests are consumed first; stray rvalid is ignored
   assign resp_drop = i_imem_rvalid & (discard != '0);
   assign resp_take = i_imem_rvalid & (discard == '0) & (outstanding != '0);

   // On redirect every response still owed is dropped, less the one arriving now
   assign owed_after = owed - (CW+1)'(i_imem_rvalid && (owed != '0));

   assign q_push  = i_clk_en & ~i_redirect_h & resp_take;
   assign q_pop   = i_clk_en & ~i_redirect_h & ~i_if_id_flush_h & ~i_if_id_stall_h & ~q_empty;
   assign q_clear = i_clk_en & i_redirect_h;

   assign o_imem_req  = req;
   assign o_imem_addr = fetch_pc;
   assign o_q_count   = q_count;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (q_push),
      .i_pop   (q_pop),
      .i_clear (q_clear),
      .i_data  ({resp_pc, i_imem_rdata}),
      .o_data  (q_head),
      .o_count (q_count),
      .o_empty (q_empty),
      .o_full  (q_full)
   );

   // Next-state for PCs and in-flight counters
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      resp_pc_nxt     = resp_pc;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      if (i_redirect_h) begin
         fetch_pc_nxt    = i_redirect_pc;
         resp_pc_nxt     = i_redirect_pc;
         outstanding_nxt = '0;
         discard_nxt     = CW'(owed_after);
      end else begin
         if (issue)     fetch_pc_nxt = fetch_pc + XLEN'(4);
         if (resp_take) resp_pc_nxt  = resp_pc + XLEN'(4);
         if (resp_drop) discard_nxt  = discard - CW'(1);
         outstanding_nxt = outstanding + CW'(issue) - CW'(resp_take);
      end
   end

   // Next-state for IF/ID: redirect > flush > stall > advance
   always_comb begin
      valid_nxt    = o_valid_d;
      instr_nxt    = o_instr_d;
      pc_nxt       = o_pc_d;
      pc_plus4_nxt = o_pc_plus4_d;
      if (i_redirect_h || i_if_id_flush_h || (!i_if_id_stall_h && q_empty)) begin
         valid_nxt    = 1'b0;
         instr_nxt    = NOP_INSTR;
         pc_nxt       = '0;
         pc_plus4_nxt = '0;
      end else if (!i_if_id_stall_h) begin
         valid_nxt    = 1'b1;
         instr_nxt    = q_head[INSTR_W-1:0];
         pc_nxt       = q_head[EW-1 -: XLEN];
         pc_plus4_nxt = q_head[EW-1 -: XLEN] + XLEN'(4);
      end
   end

   // State registers; clock enable freezes everything
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc     <= RESET_PC;
         resp_pc      <= RESET_PC;
         outstanding  <= '0;
         discard      <= '0;
         o_valid_d    <= 1'b0;
         o_instr_d    <= NOP_INSTR;
         o_pc_d       <= '0;
         o_pc_plus4_d <= '0;
      end else if (i_clk_en) begin
         fetch_pc     <= fetch_pc_nxt;
         resp_pc      <= resp_pc_nxt;
         outstanding  <= outstanding_nxt;
         discard      <= discard_nxt;
         o_valid_d    <= valid_nxt;
         o_instr_d    <= instr_nxt;
         o_pc_d       <= pc_nxt;
         o_pc_plus4_d <= pc_plus4_nxt;
      end
   end

   // Decode fields sliced from the registered instruction
   assign o_opcode_d = o_instr_d[OPCODE_MSB:OPCODE_LSB];
   assign o_f3_d     = o_instr_d[F3_MSB:F3_LSB];
   assign o_f7_b6_d  = o_instr_d[F7_B6_POS];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboarded bench for fetch_prefetch_unit with an in-order memory slave model.
module tb_fetch_prefetch_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_clk_en;
   logic              i_pc_wr_en_h;
   logic              i_redirect_h;
   logic [XLEN-1:0]   i_redirect_pc;
   logic              i_if_id_stall_h;
   logic              i_if_id_flush_h;
   logic              o_imem_req;
   logic [XLEN-1:0]   o_imem_addr;
   logic              i_imem_gnt;
   logic              i_imem_rvalid = 1'b0;
   logic [31:0]       i_imem_rdata  = 32'h0;
   logic              o_valid_d;
   logic [31:0]       o_instr_d;
   logic [XLEN-1:0]   o_pc_d;
   logic [XLEN-1:0]   o_pc_plus4_d;
   logic [6:0]        o_opcode_d;
   logic [2:0]        o_f3_d;
   logic              o_f7_b6_d;
   logic [2:0]        o_q_count;

   fetch_prefetch_unit #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_clk_en        (i_clk_en),
      .i_pc_wr_en_h    (i_pc_wr_en_h),
      .i_redirect_h    (i_redirect_h),
      .i_redirect_pc   (i_redirect_pc),
      .i_if_id_stall_h (i_if_id_stall_h),
      .i_if_id_flush_h (i_if_id_flush_h),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_gnt      (i_imem_gnt),
      .i_imem_rvalid   (i_imem_rvalid),
      .i_imem_rdata    (i_imem_rdata),
      .o_valid_d       (o_valid_d),
      .o_instr_d       (o_instr_d),
      .o_pc_d          (o_pc_d),
      .o_pc_plus4_d    (o_pc_plus4_d),
      .o_opcode_d      (o_opcode_d),
      .o_f3_d          (o_f3_d),
      .o_f7_b6_d       (o_f7_b6_d),
      .o_q_count       (o_q_count)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   // Memory image: instruction word as a scrambled function of its address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // In-order memory slave: grants captured at posedge, responses driven at negedge
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          cyc = 0;
   int          lat = 1;

   always @(posedge i_clk) begin : mem_accept
      if (i_clk_en && i_imem_rvalid && pend_addr.size() > 0) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (o_imem_req && i_imem_gnt) begin
         pend_addr.push_back(o_imem_addr);
         pend_due.push_back(cyc + lat);
      end
      cyc++;
   end

   always @(negedge i_clk) begin : mem_respond
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mem_word(pend_addr[0]);
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = 32'h0;
      end
   end

   // Scoreboard of expected program-order PCs
   logic [31:0] exp_pc_q[$];
   int          delivered = 0;
   logic [31:0] last_pc = 32'h0;
   logic        mon_load;

   task automatic expect_from(input logic [31:0] base);
      exp_pc_q.delete();
      for (int i = 0; i < 100; i++) exp_pc_q.push_back(base + 32'(4 * i));
   endtask

   // Monitor: every IF/ID load carrying a real instruction is compared to the scoreboard head
   always @(posedge i_clk) begin : monitor
      logic [31:0] e;
      logic [31:0] w;
      mon_load = !i_rst && i_clk_en && !i_redirect_h && !i_if_id_flush_h && !i_if_id_stall_h;
      #1;
      if (mon_load && o_valid_d) begin
         if (exp_pc_q.size() == 0) begin
            checks++;
            $display("FAIL mon_unexpected: actual pc %h required no instruction", o_pc_d);
         end else begin
            e = exp_pc_q.pop_front();
            w = mem_word(e);
            chk("mon_pc", o_pc_d, e);
            chk("mon_instr", o_instr_d, w);
            chk("mon_pc4", o_pc_plus4_d, e + 32'd4);
            chk("mon_opcode", 32'(o_opcode_d), 32'(w[6:0]));
            chk("mon_f3", 32'(o_f3_d), 32'(w[14:12]));
            chk("mon_f7b6", 32'(o_f7_b6_d), 32'(w[30]));
            last_pc = e;
            delivered++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   logic [31:0] fpc;

   initial begin
      i_rst = 1'b1;
      i_clk_en = 1'b1;
      i_pc_wr_en_h = 1'b1;
      i_redirect_h = 1'b0;
      i_redirect_pc = 32'h0;
      i_if_id_stall_h = 1'b0;
      i_if_id_flush_h = 1'b0;
      i_imem_gnt = 1'b0;
      step(2);

      // Reset state
      chk("rst_valid", 32'(o_valid_d), 32'd0);
      chk("rst_instr", o_instr_d, NOP);
      chk("rst_pc", o_pc_d, 32'h0);
      chk("rst_pc4", o_pc_plus4_d, 32'h0);
      chk("rst_addr", o_imem_addr, 32'h0);
      chk("rst_req", 32'(o_imem_req), 32'd0);
      chk("rst_qcount", 32'(o_q_count), 32'd0);
      i_rst = 1'b0;
      expect_from(32'h0);

      // Address held stable without grant, then advances after the first grant
      step(1);
      chk("hold_req", 32'(o_imem_req), 32'd1);
      chk("hold_addr", o_imem_addr, 32'h0);
      i_imem_gnt = 1'b1;
      step(1);
      chk("first_gnt_addr", o_imem_addr, 32'h4);

      // Streaming at one-cycle latency
      step(10);
      chk("stream_pc", o_pc_d, 32'h20);
      chk("stream_valid", 32'(o_valid_d), 32'd1);
      chk("stream_count", 32'(delivered), 32'd9);
      chk("stream_qcount", 32'(o_q_count), 32'd1);

      // Backpressure: queue saturates, issue stops, IF/ID holds
      i_if_id_stall_h = 1'b1;
      lat = 2;
      step(10);
      chk("bp_qcount", 32'(o_q_count), 32'd4);
      chk("bp_req", 32'(o_imem_req), 32'd0);
      chk("bp_pc", o_pc_d, 32'h20);
      chk("bp_instr", o_instr_d, mem_word(32'h20));
      chk("bp_valid", 32'(o_valid_d), 32'd1);
      i_if_id_stall_h = 1'b0;
      step(12);

      // Drain to an idle state
      i_pc_wr_en_h = 1'b0;
      step(10);
      chk("drain_qcount", 32'(o_q_count), 32'd0);
      chk("drain_valid", 32'(o_valid_d), 32'd0);

      // Redirect with three requests in flight
      lat = 6;
      i_pc_wr_en_h = 1'b1;
      step(3);
      i_redirect_h = 1'b1;
      i_redirect_pc = 32'h100;
      lat = 1;
      #1;
      chk("redir_req", 32'(o_imem_req), 32'd0);
      expect_from(32'h100);
      step(1);
      i_redirect_h = 1'b0;
      #1;
      chk("redir_qcount", 32'(o_q_count), 32'd0);
      chk("redir_valid", 32'(o_valid_d), 32'd0);
      chk("redir_addr", o_imem_addr, 32'h100);
      chk("redir_req_after", 32'(o_imem_req), 32'd1);
      step(30);
      chk("redir_stream_valid", 32'(o_valid_d), 32'd1);

      // Clock enable low freezes outputs and blocks requests
      i_clk_en = 1'b0;
      #1;
      chk("ce_req", 32'(o_imem_req), 32'd0);
      fpc = last_pc;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("ce_valid", 32'(o_valid_d), 32'd1);
         chk("ce_pc", o_pc_d, fpc);
         chk("ce_instr", o_instr_d, mem_word(fpc));
         chk("ce_req_hold", 32'(o_imem_req), 32'd0);
      end
      i_clk_en = 1'b1;
      step(3);

      // Flush and stall together: flush wins, queue head survives
      fpc = last_pc;
      i_if_id_flush_h = 1'b1;
      i_if_id_stall_h = 1'b1;
      step(1);
      i_if_id_flush_h = 1'b0;
      i_if_id_stall_h = 1'b0;
      chk("flush_valid", 32'(o_valid_d), 32'd0);
      chk("flush_instr", o_instr_d, NOP);
      chk("flush_pc", o_pc_d, 32'h0);
      chk("flush_pc4", o_pc_plus4_d, 32'h0);
      step(1);
      chk("flush_next_valid", 32'(o_valid_d), 32'd1);
      chk("flush_next_pc", o_pc_d, fpc + 32'd4);
      step(5);

      // Reset with two requests outstanding; late responses must be ignored
      i_pc_wr_en_h = 1'b0;
      step(10);
      lat = 10;
      i_pc_wr_en_h = 1'b1;
      step(2);
      i_rst = 1'b1;
      #1;
      chk("mrst_valid", 32'(o_valid_d), 32'd0);
      chk("mrst_instr", o_instr_d, NOP);
      chk("mrst_pc", o_pc_d, 32'h0);
      chk("mrst_addr", o_imem_addr, 32'h0);
      chk("mrst_req", 32'(o_imem_req), 32'd0);
      chk("mrst_qcount", 32'(o_q_count), 32'd0);
      exp_pc_q.delete();
      step(2);
      i_pc_wr_en_h = 1'b0;
      i_rst = 1'b0;
      step(14);
      chk("late_qcount", 32'(o_q_count), 32'd0);
      chk("late_valid", 32'(o_valid_d), 32'd0);
      lat = 1;
      expect_from(32'h0);
      i_pc_wr_en_h = 1'b1;
      #1;
      chk("restart_req", 32'(o_imem_req), 32'd1);
      chk("restart_addr", o_imem_addr, 32'h0);
      step(3);
      chk("restart_valid", 32'(o_valid_d), 32'd1);
      chk("restart_pc", o_pc_d, 32'h0);
      chk("restart_instr", o_instr_d, mem_word(32'h0));
      step(4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
